spi_display_receiver: RTL
=========================

SPI_DISPLAY_RECEIVER -- requirements
Module: spi_display_receiver

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning number of received entries buffered; power of two, >= 2.
REQ-002 SHALL have port CLK  in  1  system clock; all logic on rising edge.
REQ-003 SHALL have port RESET  in  1  reset; synchronous, active-high.
REQ-004 SHALL have port sck  in  1  SPI serial clock from the driver, asynchronous to CLK.
REQ-005 SHALL have port cs  in  1  chip select, active-low, asynchronous.
REQ-006 SHALL have port mosi  in  1  serial data from the driver, MSB first.
REQ-007 SHALL have port dc  in  1  data/command flag from the driver (1 = data, 0 = command).
REQ-008 SHALL have port miso  out  1  serial response bit to the driver.
REQ-009 SHALL have port tx_data  in  8  byte returned on miso during the next byte slot.
REQ-010 SHALL have port rd_en  in  1  pop the FIFO head.
REQ-011 SHALL have port rx_data  out  8  FIFO head byte (show-ahead), valid when rx_empty = 0.
REQ-012 SHALL have port rx_dc  out  1  dc value captured with rx_data.
REQ-013 SHALL have port rx_empty  out  1  FIFO empty.
REQ-014 SHALL have port rx_full  out  1  FIFO full.
REQ-015 SHALL have port clr_flags  in  1  clear sticky error flags.
REQ-016 SHALL have port overflow  out  1  sticky; byte dropped on full FIFO.
REQ-017 SHALL have port frame_err  out  1  sticky; cs deasserted mid-byte.

Function
REQ-018 SHALL pass sck, cs, mosi and dc each through a 2-flop synchronizer; edges SHALL be detected as sync & ~sync_d; the resulting actions SHALL be registered on the next CLK edge.
REQ-019 Input constraint: sck high and low phases are each >= 3 CLK periods; mosi and dc are stable >= 1 CLK period before the sck rising edge.
REQ-020 SHALL implement states IDLE and ACTIVE; IDLE -> ACTIVE on a synchronized cs falling edge only; ACTIVE -> IDLE on a synchronized cs rising edge.
REQ-021 On IDLE -> ACTIVE: bitcnt := 0, tx shift register := tx_data.
REQ-022 In ACTIVE, on each sck rising edge: rx shift := {rx shift[6:0], mosi}, bitcnt += 1.
REQ-023 On the 8th rising edge: push {dc, assembled byte} into the FIFO (dc sampled at this edge), bitcnt := 0, tx shift := tx_data.
REQ-024 In ACTIVE, on an sck falling edge with bitcnt != 0: tx shift shifts left by one.
REQ-025 miso SHALL equal tx shift[7] in ACTIVE and 0 in IDLE (SPI mode 0).
REQ-026 rx_empty SHALL deassert 2 CLK cycles after the CLK edge that first captures the 8th sck high into synchronizer stage 1.
REQ-027 Full FIFO with push and no pop: the byte is dropped and overflow := 1.
REQ-028 Full FIFO with simultaneous push and rd_en: both SHALL occur; no overflow.
REQ-029 rd_en while rx_empty = 1 SHALL be ignored; pointers wrap modulo FIFO_DEPTH.
REQ-030 cs rising edge with bitcnt != 0: the partial byte is discarded, no push, frame_err := 1.
REQ-031 sck edges while in IDLE SHALL be ignored.
REQ-032 clr_flags SHALL clear overflow and frame_err; a same-cycle set event SHALL take priority.

Reset
REQ-033 RESET SHALL force: state IDLE, bitcnt 0, both shift registers 0, FIFO empty (rx_empty 1, rx_full 0, rx_data 0, rx_dc 0), miso 0, overflow 0, frame_err 0.
REQ-034 Synchronizer flops SHALL reset to idle levels: cs 1, sck 0, mosi 0, dc 0. No false edge SHALL be detected on reset release.
REQ-035 If cs is still low when RESET is released, the block SHALL remain IDLE until a new cs falling edge.

Verification
REQ-036 cs low, dc = 1, send 0xA5, cs high -> one entry: rx_data 0xA5, rx_dc 1; frame_err 0.
REQ-037 tx_data = 0x3C at cs fall, send 0x00 -> miso sampled on the 8 sck rising edges reads 0x3C, MSB first.
REQ-038 FIFO_DEPTH = 4, send 5 bytes with no rd_en -> rx_full 1, first 4 bytes retained in order, overflow 1. Repeat with rd_en on the 5th push -> no overflow.
REQ-039 cs high after 5 bits -> no push, frame_err 1. clr_flags -> frame_err 0. Next full byte received correctly.
REQ-040 Assert RESET mid-byte with cs held low -> all outputs at reset values. Bytes are ignored until cs rises and falls again, after which 0x81 is received correctly.

Source files
------------

// File: rtl/spi_display_receiver_if.sv
// Bus bundle between an SPI display driver model/host logic and spi_display_receiver.
// The slave modport is the receiver's view; the master modport is the driving side.
interface spi_display_receiver_if;
    logic       sck;
    logic       cs;
    logic       mosi;
    logic       dc;
    logic       miso;
    logic [7:0] tx_data;
    logic       rd_en;
    logic [7:0] rx_data;
    logic       rx_dc;
    logic       rx_empty;
    logic       rx_full;
    logic       clr_flags;
    logic       overflow;
    logic       frame_err;

    modport slave (
        input  sck, cs, mosi, dc, tx_data, rd_en, clr_flags,
        output miso, rx_data, rx_dc, rx_empty, rx_full, overflow, frame_err
    );

    modport master (
        output sck, cs, mosi, dc, tx_data, rd_en, clr_flags,
        input  miso, rx_data, rx_dc, rx_empty, rx_full, overflow, frame_err
    );
endinterface

// File: rtl/spi_display_receiver.sv
// SPI mode-0 display receiver: oversamples sck/cs/mosi/dc in the CLK domain, assembles
// bytes tagged with dc into a show-ahead FIFO and shifts tx_data back out on miso.
module spi_display_receiver #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    spi_display_receiver_if.slave bus
);
    localparam int          PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW:0] DEPTH_CNT = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    state_t        r_state, w_state_next;
    logic          r_sck_meta, r_sck_sync, r_sck_sync_d;
    logic          r_cs_meta, r_cs_sync, r_cs_sync_d;
    logic          r_mosi_meta, r_mosi_sync;
    logic          r_dc_meta, r_dc_sync;
    logic [1:0]    r_settle;
    logic          r_cs_armed;
    logic [2:0]    r_bitcnt, w_bitcnt_next;
    logic [7:0]    r_rx_shift, w_rx_shift_next;
    logic [7:0]    r_tx_shift, w_tx_shift_next;
    logic          r_miso;
    logic [7:0]    r_mem_data [FIFO_DEPTH];
    logic          r_mem_dc   [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [PW:0]   r_count, w_count_next;
    logic          r_rx_empty, r_rx_full, r_overflow, r_frame_err;
    logic          w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;
    logic          w_push, w_pop, w_do_push, w_ovf_set, w_frame_set;

    // Input synchronizers; r_cs_armed blocks a cs falling edge until cs has been seen high post-reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sck_meta   <= 1'b0;
            r_sck_sync   <= 1'b0;
            r_sck_sync_d <= 1'b0;
            r_cs_meta    <= 1'b1;
            r_cs_sync    <= 1'b1;
            r_cs_sync_d  <= 1'b1;
            r_mosi_meta  <= 1'b0;
            r_mosi_sync  <= 1'b0;
            r_dc_meta    <= 1'b0;
            r_dc_sync    <= 1'b0;
            r_settle     <= 2'd0;
            r_cs_armed   <= 1'b0;
        end else begin
            r_sck_meta   <= bus.sck;
            r_sck_sync   <= r_sck_meta;
            r_sck_sync_d <= r_sck_sync;
            r_cs_meta    <= bus.cs;
            r_cs_sync    <= r_cs_meta;
            r_cs_sync_d  <= r_cs_sync;
            r_mosi_meta  <= bus.mosi;
            r_mosi_sync  <= r_mosi_meta;
            r_dc_meta    <= bus.dc;
            r_dc_sync    <= r_dc_meta;
            if (r_settle != 2'd3) begin
                r_settle <= r_settle + 2'd1;
            end
            if ((r_settle == 2'd3) && r_cs_sync && r_cs_sync_d) begin
                r_cs_armed <= 1'b1;
            end
        end
    end

    assign w_sck_rise = r_sck_sync & ~r_sck_sync_d;
    assign w_sck_fall = ~r_sck_sync & r_sck_sync_d;
    assign w_cs_rise  = r_cs_sync & ~r_cs_sync_d;
    assign w_cs_fall  = ~r_cs_sync & r_cs_sync_d & r_cs_armed;

    // Next-state and datapath decode; cs activity outranks sck activity in the same cycle
    always_comb begin
        w_state_next    = r_state;
        w_bitcnt_next   = r_bitcnt;
        w_rx_shift_next = r_rx_shift;
        w_tx_shift_next = r_tx_shift;
        w_push          = 1'b0;
        w_frame_set     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cs_fall) begin
                    w_state_next    = ACTIVE;
                    w_bitcnt_next   = 3'd0;
                    w_tx_shift_next = bus.tx_data;
                end else begin
                    w_state_next = IDLE;
                end
            end
            ACTIVE: begin
                if (w_cs_rise) begin
                    w_state_next  = IDLE;
                    w_bitcnt_next = 3'd0;
                    w_frame_set   = (r_bitcnt != 3'd0);
                end else if (w_sck_rise) begin
                    w_rx_shift_next = {r_rx_shift[6:0], r_mosi_sync};
                    if (r_bitcnt == 3'd7) begin
                        w_push          = 1'b1;
                        w_bitcnt_next   = 3'd0;
                        w_tx_shift_next = bus.tx_data;
                    end else begin
                        w_bitcnt_next = r_bitcnt + 3'd1;
                    end
                end else if (w_sck_fall && (r_bitcnt != 3'd0)) begin
                    w_tx_shift_next = {r_tx_shift[6:0], 1'b0};
                end else begin
                    w_state_next = ACTIVE;
                end
            end
            default: begin
                w_state_next  = IDLE;
                w_bitcnt_next = 3'd0;
            end
        endcase
    end

    // FSM and shift registers; miso is registered from the next-state view so it tracks tx_shift[7]
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= IDLE;
            r_bitcnt   <= 3'd0;
            r_rx_shift <= 8'h00;
            r_tx_shift <= 8'h00;
            r_miso     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_bitcnt   <= w_bitcnt_next;
            r_rx_shift <= w_rx_shift_next;
            r_tx_shift <= w_tx_shift_next;
            r_miso     <= (w_state_next == ACTIVE) ? w_tx_shift_next[7] : 1'b0;
        end
    end

    assign w_pop        = bus.rd_en & ~r_rx_empty;
    assign w_do_push    = w_push & (~r_rx_full | w_pop);
    assign w_ovf_set    = w_push & r_rx_full & ~w_pop;
    assign w_count_next = r_count + {{PW{1'b0}}, w_do_push} - {{PW{1'b0}}, w_pop};

    // Receive FIFO storage, pointers, status and sticky error flags (set wins over clear)
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_data[i] <= 8'h00;
                r_mem_dc[i]   <= 1'b0;
            end
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rx_empty  <= 1'b1;
            r_rx_full   <= 1'b0;
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_mem_data[r_wr_ptr] <= w_rx_shift_next;
                r_mem_dc[r_wr_ptr]   <= r_dc_sync;
                r_wr_ptr             <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count    <= w_count_next;
            r_rx_empty <= (w_count_next == '0);
            r_rx_full  <= (w_count_next == DEPTH_CNT);
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (bus.clr_flags) begin
                r_overflow <= 1'b0;
            end
            if (w_frame_set) begin
                r_frame_err <= 1'b1;
            end else if (bus.clr_flags) begin
                r_frame_err <= 1'b0;
            end
        end
    end

    assign bus.miso      = r_miso;
    assign bus.rx_data   = r_mem_data[r_rd_ptr];
    assign bus.rx_dc     = r_mem_dc[r_rd_ptr];
    assign bus.rx_empty  = r_rx_empty;
    assign bus.rx_full   = r_rx_full;
    assign bus.overflow  = r_overflow;
    assign bus.frame_err = r_frame_err;
endmodule
